nf_rf_wr_arb: RTL and testbench

Write-port arbiter and scheduler for the single-write-port register file. It shares the write port between the pipeline writeback stage and load data returning from the LSU. Load data that cannot be written immediately is parked in a small FIFO. The block enforces write-after-write ordering and prevents load starvation, and it reports pending-load hazards to the decode stage.

---
 rtl/nf_rf_wr_arb.sv | 139 +++++++++++++
 tb/tb_nf_rf_wr_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_rf_wr_arb.sv
// Register-file write-port arbiter.
// Shares the single write port between pipeline writeback (wb_*) and load
// data returning from the LSU (lsu_*). Loads that cannot be written at once
// are parked in a small FIFO. A parked load always reaches the register file
// before a younger writeback to the same register. A head entry that keeps
// losing arbitration is forced through after MAX_WAIT cycles. Decode is told
// which read addresses still have a parked load outstanding.
//
// Handshake semantics:
//   wb  : the pipeline presents wb_we/wb_wa/wb_wd. When wb_stall = 1 the write
//         did not happen and the pipeline re-presents the same request next
//         cycle. A request to x0 is ignored and never stalled.
//   lsu : a transfer occurs in every cycle where lsu_vld & lsu_rdy. lsu_rdy
//         does not depend on lsu_vld. The LSU holds lsu_wa/lsu_wd while
//         lsu_vld = 1 and lsu_rdy = 0. A transfer to x0 is consumed and
//         dropped.
module nf_rf_wr_arb #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  output logic        wb_stall,
  input  logic        lsu_vld,
  input  logic [4:0]  lsu_wa,
  input  logic [31:0] lsu_wd,
  output logic        lsu_rdy,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hz1,
  output logic        hz2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [SW-1:0] starve_cnt;

  logic [PW-1:0]    ent_off [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic             wb_match, r1_match, r2_match;
  logic             wb_eff, wb_conf, force_head, lsu_hs;
  logic             pop, wb_grant, bypass, push;

  // Occupancy of every FIFO slot, and address matches against occupied slots.
  always_comb begin
    wb_match = 1'b0;
    r1_match = 1'b0;
    r2_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i] = PW'(i) - rd_ptr;
      ent_vld[i] = (CW'(ent_off[i]) < count);
      if (ent_vld[i] && (fifo_wa[i] == wb_wa)) wb_match = 1'b1;
      if (ent_vld[i] && (fifo_wa[i] == ra1))   r1_match = 1'b1;
      if (ent_vld[i] && (fifo_wa[i] == ra2))   r2_match = 1'b1;
    end
  end

  // Grant decision: FIFO head, then writeback, then direct LSU bypass.
  always_comb begin
    wb_eff     = resetn && wb_we && (wb_wa != 5'd0);
    wb_conf    = wb_eff && wb_match;
    force_head = (count != '0) && (starve_cnt == SW'(MAX_WAIT));
    lsu_rdy    = resetn && (count < CW'(DEPTH));
    lsu_hs     = lsu_vld && lsu_rdy && (lsu_wa != 5'd0);
    pop        = resetn && (count != '0) && (!wb_eff || wb_conf || force_head);
    wb_grant   = !pop && wb_eff;
    bypass     = !pop && !wb_eff && (count == '0) && lsu_hs;
    push       = lsu_hs && !bypass;
    wb_stall   = pop && wb_eff;
    hz1        = resetn && (ra1 != 5'd0) && r1_match;
    hz2        = resetn && (ra2 != 5'd0) && r2_match;
  end

  // Write-port mux driven by the grant decision.
  always_comb begin
    we3 = 1'b0;
    wa3 = 5'd0;
    wd3 = 32'd0;
    if (pop) begin
      we3 = 1'b1;
      wa3 = fifo_wa[rd_ptr];
      wd3 = fifo_wd[rd_ptr];
    end else if (wb_grant) begin
      we3 = 1'b1;
      wa3 = wb_wa;
      wd3 = wb_wd;
    end else if (bypass) begin
      we3 = 1'b1;
      wa3 = lsu_wa;
      wd3 = lsu_wd;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // FIFO storage; only occupied slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= lsu_wa;
      fifo_wd[wr_ptr] <= lsu_wd;
    end
  end

  // Pointers, occupancy and the head starvation counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (pop || (count_nxt == '0))
        starve_cnt <= '0;
      else if ((count != '0) && (starve_cnt != SW'(MAX_WAIT)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_nf_rf_wr_arb.sv
// Bench for nf_rf_wr_arb: a queue-based reference model predicts every
// cycle's outputs; a negedge monitor compares them and tracks register state.
module tb_nf_rf_wr_arb;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 3;
  localparam int VW       = 42;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  logic        wb_we = 1'b0;
  logic [4:0]  wb_wa = '0;
  logic [31:0] wb_wd = '0;
  logic        wb_stall;
  logic        lsu_vld = 1'b0;
  logic [4:0]  lsu_wa = '0;
  logic [31:0] lsu_wd = '0;
  logic        lsu_rdy;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        hz1, hz2;

  nf_rf_wr_arb #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_stall(wb_stall),
    .lsu_vld(lsu_vld), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd), .lsu_rdy(lsu_rdy),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2)
  );

  // ---------------- reference model state ----------------
  logic [VW-1:0] exp_q[$];      // {we3, wa3, wd3, wb_stall, lsu_rdy, hz1, hz2}
  logic [36:0]   rf_q[$];       // {addr, expected register value}
  logic [36:0]   pend_q[$];     // parked loads {wa, wd}, oldest first
  int            starve = 0;
  logic [31:0]   mdl_rf [32];
  logic [31:0]   dut_rf [32];
  logic          m_stall, m_lsu_acc;
  int            checks = 0;
  int            passed = 0;

  // ---------------- driver tasks ----------------
  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      resetn  = 1'b0;
      wb_we   = 1'b1; wb_wa = 5'd3; wb_wd = 32'h1234;
      lsu_vld = 1'b1; lsu_wa = 5'd4; lsu_wd = 32'h5678;
      ra1 = 5'd4; ra2 = 5'd3;
      exp_q.push_back('0);
      pend_q.delete();
      starve = 0;
    end
  endtask

  task automatic cycle(input logic wwe, input logic [4:0] wwa, input logic [31:0] wwd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit          wb_eff, conf, frc, rdy, hs, pop, byp, push, h1, h2, we;
    logic [4:0]  a;
    logic [31:0] d;
    int          sz;
    @(posedge clk); #1;
    resetn = 1'b1;
    wb_we = wwe; wb_wa = wwa; wb_wd = wwd;
    lsu_vld = lv; lsu_wa = lwa; lsu_wd = lwd;
    ra1 = r1; ra2 = r2;
    sz = pend_q.size();
    wb_eff = wwe && (wwa != 5'd0);
    conf = 0; h1 = 0; h2 = 0;
    foreach (pend_q[k]) begin
      if (wb_eff && pend_q[k][36:32] == wwa) conf = 1;
      if (r1 != 5'd0 && pend_q[k][36:32] == r1) h1 = 1;
      if (r2 != 5'd0 && pend_q[k][36:32] == r2) h2 = 1;
    end
    frc  = (sz > 0) && (starve == MAX_WAIT);
    rdy  = sz < DEPTH;
    hs   = lv && rdy && (lwa != 5'd0);
    pop  = (sz > 0) && (!wb_eff || conf || frc);
    byp  = (sz == 0) && !wb_eff && hs;
    push = hs && !byp;
    we = 0; a = '0; d = '0;
    if (pop) begin
      we = 1; a = pend_q[0][36:32]; d = pend_q[0][31:0];
    end else if (wb_eff) begin
      we = 1; a = wwa; d = wwd;
    end else if (byp) begin
      we = 1; a = lwa; d = lwd;
    end
    if (we) mdl_rf[a] = d;
    exp_q.push_back({we, a, d, pop && wb_eff, rdy, h1, h2});
    if (pop)  void'(pend_q.pop_front());
    if (push) pend_q.push_back({lwa, lwd});
    if (pop || pend_q.size() == 0) starve = 0;
    else if (sz > 0 && starve < MAX_WAIT) starve++;
    m_stall   = pop && wb_eff;
    m_lsu_acc = lv && rdy;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [4:0] r1);
    int guard;
    guard = 0;
    do begin
      cycle(1'b1, a, d, 1'b0, 5'd0, 32'd0, r1, 5'd0);
      guard++;
    end while (m_stall && guard < 10);
  endtask

  task automatic traffic(input int n, input int wb_pct, input int lsu_pct, input int amax);
    logic        wv, lv;
    logic [4:0]  wa, la;
    logic [31:0] wd, ld;
    wv = 0; lv = 0; wa = '0; la = '0; wd = '0; ld = '0;
    repeat (n) begin
      if (!wv && $urandom_range(99) < wb_pct) begin
        wv = 1; wa = 5'($urandom_range(amax)); wd = $urandom;
      end
      if (!lv && $urandom_range(99) < lsu_pct) begin
        lv = 1; la = 5'($urandom_range(amax)); ld = $urandom;
      end
      cycle(wv, wa, wd, lv, la, ld, 5'($urandom_range(amax)), 5'($urandom_range(amax)));
      if (!m_stall) wv = 0;
      if (m_lsu_acc) lv = 0;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [VW-1:0] e, got;
    logic [36:0]   r;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {we3, wa3, wd3, wb_stall, lsu_rdy, hz1, hz2};
      checks++;
      if (got === e) passed++;
      else $display("FAIL outputs t=%0t got=%h expected=%h", $time, got, e);
      if (resetn && we3) dut_rf[wa3] = wd3;
    end
    while (rf_q.size() > 0) begin
      r = rf_q.pop_front();
      checks++;
      if (dut_rf[r[36:32]] === r[31:0]) passed++;
      else $display("FAIL regfile x%0d got=%h expected=%h", r[36:32], dut_rf[r[36:32]], r[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      mdl_rf[i] = '0;
      dut_rf[i] = '0;
    end
    reset_cycles(3);

    // Idle writeback: load goes straight to the port, no hazard raised.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);

    // Load parked behind a writeback stream, then forced through.
    cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
    wb_write(5'd2, 32'h102, 5'd7);
    wb_write(5'd3, 32'h103, 5'd7);
    wb_write(5'd4, 32'h104, 5'd7);
    wb_write(5'd6, 32'h106, 5'd7);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    rf_q.push_back({5'd7, 32'h11});

    // Write-after-write on x9.
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd0);
    wb_write(5'd9, 32'hBB, 5'd9);
    rf_q.push_back({5'd9, 32'hBB});

    // Fill the FIFO under continuous writeback traffic.
    traffic(20, 100, 100, 31);

    // x0 targets: full FIFO with a wb to x0, then an LSU transfer to x0.
    cycle(1'b1, 5'd11, 32'h1, 1'b1, 5'd12, 32'hC12, 5'd12, 5'd13);
    cycle(1'b1, 5'd11, 32'h2, 1'b1, 5'd13, 32'hC13, 5'd12, 5'd13);
    cycle(1'b1, 5'd0,  32'h3, 1'b0, 5'd0,  32'd0,   5'd12, 5'd13);
    cycle(1'b1, 5'd0,  32'h4, 1'b1, 5'd0,  32'h55,  5'd0,  5'd13);
    cycle(1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  32'h66,  5'd13, 5'd0);
    traffic(6, 0, 0, 31);

    // Randomised mix, narrow address range for frequent conflicts.
    traffic(1500, 60, 50, 7);
    traffic(500, 90, 90, 31);

    // Reset while loads are parked, then resume.
    traffic(10, 100, 100, 7);
    reset_cycles(2);
    traffic(300, 70, 70, 7);
    traffic(8, 0, 0, 7);

    for (int i = 1; i < 32; i++) rf_q.push_back({5'(i), mdl_rf[i]});
    @(posedge clk); #1;
    wb_we = 1'b0; lsu_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
